// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-word output bundle of the UART receive engine
`timescale 1ns/1ps

interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] dout;
  logic                 rx_done;
  logic                 frame_err;
  logic                 busy;

  // receive engine drives the word, the FIFO side consumes it
  modport master (output dout, rx_done, frame_err, busy);
  modport slave  (input  dout, rx_done, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x-oversampled UART receive engine with framing-error flag
`timescale 1ns/1ps

module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      bclk,
  input  logic      rx,
  uart_rx_if.master rx_o
);

  localparam int S_W = $clog2(OVERSAMPLE);
  localparam int N_W = ($clog2(DATA_BITS) < 1) ? 1 : $clog2(DATA_BITS);

  localparam logic [S_W-1:0] S_HALF = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_ONE  = S_W'(1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);
  localparam logic [N_W-1:0] N_ONE  = N_W'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e               state_q, state_d;
  logic [S_W-1:0]       s_cnt_q, s_cnt_d;
  logic [N_W-1:0]       n_cnt_q, n_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 rx_done_q, rx_done_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;
  logic [1:0]           sync_q, sync_d;
  logic                 rx_s;

  assign rx_s = sync_q[1];

  // next-state: sequencing advances only on oversample ticks; rx_done drops every cycle
  always_comb begin
    state_d     = state_q;
    s_cnt_d     = s_cnt_q;
    n_cnt_d     = n_cnt_q;
    shreg_d     = shreg_q;
    dout_d      = dout_q;
    frame_err_d = frame_err_q;
    rx_done_d   = 1'b0;
    sync_d      = {sync_q[0], rx};

    if (bclk) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            s_cnt_d = '0;
          end
        end
        START: begin
          if (s_cnt_q == S_HALF) begin
            // a line back high at mid start bit is treated as noise
            if (!rx_s) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + S_ONE;
          end
        end
        DATA: begin
          if (s_cnt_q == S_LAST) begin
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            s_cnt_d = '0;
            if (n_cnt_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_cnt_d = n_cnt_q + N_ONE;
            end
          end else begin
            s_cnt_d = s_cnt_q + S_ONE;
          end
        end
        STOP: begin
          if (s_cnt_q == S_LAST) begin
            state_d     = IDLE;
            dout_d      = shreg_q;
            frame_err_d = ~rx_s;
            rx_done_d   = 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + S_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // state, counters, synchronizer and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_cnt_q     <= '0;
      n_cnt_q     <= '0;
      shreg_q     <= '0;
      dout_q      <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      sync_q      <= 2'b11;
    end else begin
      state_q     <= state_d;
      s_cnt_q     <= s_cnt_d;
      n_cnt_q     <= n_cnt_d;
      shreg_q     <= shreg_d;
      dout_q      <= dout_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      sync_q      <= sync_d;
    end
  end

  assign rx_o.dout      = dout_q;
  assign rx_o.rx_done   = rx_done_q;
  assign rx_o.frame_err = frame_err_q;
  assign rx_o.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx (8N1/16x and 7-bit/8x instances)
`timescale 1ns/1ps

module tb_uart_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bclk = 1'b0;
  logic rx8 = 1'b1;
  logic rx7 = 1'b1;

  int div = 1;
  int tcnt = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int start8 = 0, start7 = 0;
  int done8_cyc = 0, done7_cyc = 0;
  int ndone8 = 0, ndone7 = 0;

  logic [9:0] sb8[$];
  logic [9:0] sb7[$];
  logic [9:0] e8, e7;
  logic prev8 = 1'b0, prev7 = 1'b0;

  uart_rx_if #(.DATA_BITS(8)) if8();
  uart_rx_if #(.DATA_BITS(7)) if7();

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .bclk(bclk), .rx(rx8), .rx_o(if8)
  );

  uart_rx #(.DATA_BITS(7), .OVERSAMPLE(8)) dut7 (
    .clk(clk), .rst_n(rst_n), .bclk(bclk), .rx(rx7), .rx_o(if7)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit is7, input logic v);
    if (is7) rx7 = v;
    else     rx8 = v;
  endtask

  task automatic send(input bit is7, input logic [8:0] data, input int nbits,
                      input int os, input logic stop_v, input int stop_ticks);
    int per;
    per = os * div;
    drive(is7, 1'b0);
    if (is7) start7 = cyc;
    else     start8 = cyc;
    hold(per);
    for (int i = 0; i < nbits; i++) begin
      drive(is7, data[i]);
      hold(per);
    end
    drive(is7, stop_v);
    hold(stop_ticks * div);
    drive(is7, 1'b1);
  endtask

  // tick generator: one-cycle bclk every div clocks, constant high when div is 1
  initial forever begin
    @(negedge clk);
    tcnt = (tcnt + 1 >= div) ? 0 : tcnt + 1;
    bclk = (tcnt == 0);
  end

  // output monitors: pop expected word on each rx_done pulse
  initial forever begin
    @(negedge clk);
    if (if8.rx_done) begin
      ndone8++;
      done8_cyc = cyc;
      if (prev8) chk("done8_width", 1, 0);
      if (sb8.size() == 0) begin
        chk("unexpected_done8", 1, 0);
      end else begin
        e8 = sb8.pop_front();
        chk("dout8", if8.dout, e8[7:0]);
        chk("ferr8", if8.frame_err, e8[8]);
      end
    end
    prev8 = if8.rx_done;
  end

  initial forever begin
    @(negedge clk);
    if (if7.rx_done) begin
      ndone7++;
      done7_cyc = cyc;
      if (prev7) chk("done7_width", 1, 0);
      if (sb7.size() == 0) begin
        chk("unexpected_done7", 1, 0);
      end else begin
        e7 = sb7.pop_front();
        chk("dout7", if7.dout, e7[6:0]);
        chk("ferr7", if7.frame_err, e7[8]);
      end
    end
    prev7 = if7.rx_done;
  end

  initial begin
    #1000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    rx8 = 1'b0;
    hold(4);
    chk("rst_dout8", if8.dout, 0);
    chk("rst_done8", if8.rx_done, 0);
    chk("rst_ferr8", if8.frame_err, 0);
    chk("rst_busy8", if8.busy, 0);
    chk("rst_busy7", if7.busy, 0);
    rx8 = 1'b1;
    hold(2);
    rst_n = 1'b1;
    hold(4);

    // single frame, tick every clock, exact completion latency
    div = 1;
    sb8.push_back(10'h0A5);
    send(1'b0, 9'h0A5, 8, 16, 1'b1, 16);
    hold(4);
    chk("t1_ndone", ndone8, 1);
    chk("t1_latency", done8_cyc - start8, 155);
    chk("t1_busy", if8.busy, 0);

    // back-to-back frames, tick every 4 clocks
    div = 4;
    hold(8);
    sb8.push_back(10'h000);
    sb8.push_back(10'h0FF);
    sb8.push_back(10'h03C);
    send(1'b0, 9'h000, 8, 16, 1'b1, 16);
    send(1'b0, 9'h0FF, 8, 16, 1'b1, 16);
    send(1'b0, 9'h03C, 8, 16, 1'b1, 16);
    hold(64);
    chk("t2_ndone", ndone8, 4);

    // bad stop bit, then a good frame
    div = 1;
    hold(4);
    sb8.push_back(10'h15A);
    send(1'b0, 9'h05A, 8, 16, 1'b0, 10);
    hold(48);
    sb8.push_back(10'h081);
    send(1'b0, 9'h081, 8, 16, 1'b1, 16);
    hold(16);
    chk("t3_ndone", ndone8, 6);

    // start-bit glitch
    rx8 = 1'b0;
    hold(4);
    chk("t4_busy_mid", if8.busy, 1);
    rx8 = 1'b1;
    hold(12);
    chk("t4_busy_end", if8.busy, 0);
    hold(20);
    chk("t4_ndone", ndone8, 6);

    // reset during data bit 3 of 0xC3
    rx8 = 1'b0; hold(16);
    rx8 = 1'b1; hold(16);
    rx8 = 1'b1; hold(16);
    rx8 = 1'b0; hold(16);
    rx8 = 1'b0; hold(8);
    rst_n = 1'b0;
    rx8 = 1'b1;
    hold(1);
    rst_n = 1'b1;
    chk("t5_dout", if8.dout, 0);
    chk("t5_ferr", if8.frame_err, 0);
    chk("t5_done", if8.rx_done, 0);
    chk("t5_busy", if8.busy, 0);
    hold(200);
    chk("t5_ndone", ndone8, 6);
    sb8.push_back(10'h07E);
    send(1'b0, 9'h07E, 8, 16, 1'b1, 16);
    hold(16);
    chk("t5_ndone_after", ndone8, 7);

    // 7 data bits, 8x oversampling
    sb7.push_back(10'h055);
    send(1'b1, 9'h055, 7, 8, 1'b1, 8);
    hold(4);
    chk("t6_ndone", ndone7, 1);
    chk("t6_latency", done7_cyc - start7, 71);
    chk("t6_busy", if7.busy, 0);

    chk("sb8_empty", sb8.size(), 0);
    chk("sb7_empty", sb7.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
